// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, forwarding select and EX/MEM/WB stage tracking for the 5-stage RV32 pipeline.
// Optional feature: define PIPE_FORWARD_EN to enable EX operand forwarding (load-use-only stalls).
module pipe_hazard_ctrl #(
   parameter int RADDR_W = 5,
   parameter int CNT_W   = 16
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               start_i,
   input  logic               id_valid_i,
   input  logic [RADDR_W-1:0] id_rs1_i,
   input  logic [RADDR_W-1:0] id_rs2_i,
   input  logic               id_use_rs1_i,
   input  logic               id_use_rs2_i,
   input  logic [RADDR_W-1:0] id_rd_i,
   input  logic               id_regwrite_i,
   input  logic               id_memread_i,
   input  logic               ex_taken_i,
   output logic               pc_write_o,
   output logic               ifid_write_o,
   output logic               ifid_flush_o,
   output logic               idex_bubble_o,
   output logic [1:0]         fwd_a_o,
   output logic [1:0]         fwd_b_o,
   output logic [RADDR_W-1:0] wb_rd_o,
   output logic               wb_regwrite_o,
   output logic [CNT_W-1:0]   stall_cnt_o
);

   logic               ex_valid, ex_regwrite, ex_memread;
   logic [RADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
   logic               mem_valid, mem_regwrite, mem_memread;
   logic [RADDR_W-1:0] mem_rd;
   logic               wb_valid, wb_regwrite;
   logic [RADDR_W-1:0] wb_rd;
   logic [CNT_W-1:0]   stall_cnt;
   logic               hz, stall;

   // x0 is hard-wired zero, so a write to it never creates a dependency.
   function automatic logic writes(input logic v, input logic rw,
                                   input logic [RADDR_W-1:0] rd,
                                   input logic [RADDR_W-1:0] r);
      return v & rw & (rd == r) & (r != '0);
   endfunction

`ifdef PIPE_FORWARD_EN
   // Youngest producer wins; a load in MEM has no data yet, so it cannot forward.
   function automatic logic [1:0] fwd_sel(input logic [RADDR_W-1:0] r);
      if (writes(mem_valid, mem_regwrite, mem_rd, r) && !mem_memread)
         return 2'b10;
      else if (writes(wb_valid, wb_regwrite, wb_rd, r))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign hz = id_valid_i & ex_memread &
               ((id_use_rs1_i & writes(ex_valid, ex_regwrite, ex_rd, id_rs1_i)) |
                (id_use_rs2_i & writes(ex_valid, ex_regwrite, ex_rd, id_rs2_i)));
   assign fwd_a_o = fwd_sel(ex_rs1);
   assign fwd_b_o = fwd_sel(ex_rs2);
`else
   logic unused_fwd_fields;

   assign hz = id_valid_i &
               ((id_use_rs1_i & (writes(ex_valid, ex_regwrite, ex_rd, id_rs1_i) |
                                 writes(mem_valid, mem_regwrite, mem_rd, id_rs1_i))) |
                (id_use_rs2_i & (writes(ex_valid, ex_regwrite, ex_rd, id_rs2_i) |
                                 writes(mem_valid, mem_regwrite, mem_rd, id_rs2_i))));
   assign fwd_a_o = 2'b00;
   assign fwd_b_o = 2'b00;
   assign unused_fwd_fields = &{1'b0, ex_rs1, ex_rs2, mem_memread};
`endif

   // A taken branch squashes the stalled instruction anyway, so flush wins over stall.
   assign stall         = hz & ~ex_taken_i;
   assign pc_write_o    = start_i & ~stall;
   assign ifid_write_o  = start_i & ~stall;
   assign ifid_flush_o  = ex_taken_i;
   assign idex_bubble_o = stall | ex_taken_i;
   assign wb_rd_o       = wb_rd;
   assign wb_regwrite_o = wb_valid & wb_regwrite;
   assign stall_cnt_o   = stall_cnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ex_valid     <= 1'b0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_regwrite  <= 1'b0;
         ex_memread   <= 1'b0;
         mem_valid    <= 1'b0;
         mem_rd       <= '0;
         mem_regwrite <= 1'b0;
         mem_memread  <= 1'b0;
         wb_valid     <= 1'b0;
         wb_rd        <= '0;
         wb_regwrite  <= 1'b0;
         stall_cnt    <= '0;
      end else if (start_i) begin
         // ID -> EX, with the whole record zeroed when a bubble is inserted
         if (idex_bubble_o) begin
            ex_valid    <= 1'b0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
         end else begin
            ex_valid    <= id_valid_i;
            ex_rs1      <= id_rs1_i;
            ex_rs2      <= id_rs2_i;
            ex_rd       <= id_rd_i;
            ex_regwrite <= id_regwrite_i;
            ex_memread  <= id_memread_i;
         end
         // EX -> MEM
         mem_valid    <= ex_valid;
         mem_rd       <= ex_rd;
         mem_regwrite <= ex_regwrite;
         mem_memread  <= ex_memread;
         // MEM -> WB
         wb_valid     <= mem_valid;
         wb_rd        <= mem_rd;
         wb_regwrite  <= mem_regwrite;
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; covers both builds of PIPE_FORWARD_EN.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, start, id_valid, use1, use2, regwrite, memread, taken;
   logic [4:0] rs1, rs2, rd;
   logic       pc_write, ifid_write, ifid_flush, idex_bubble, wb_regwrite;
   logic [1:0] fwd_a, fwd_b;
   logic [4:0] wb_rd;
   logic [15:0] stall_cnt;
   logic [3:0]  sat_cnt;
   logic        unused_sat_pc, unused_sat_ifw, unused_sat_fl, unused_sat_bb, unused_sat_wr;
   logic [1:0]  unused_sat_fa, unused_sat_fb;
   logic [4:0]  unused_sat_rd;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.RADDR_W(5), .CNT_W(16)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .id_valid_i(id_valid),
      .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
      .id_rd_i(rd), .id_regwrite_i(regwrite), .id_memread_i(memread), .ex_taken_i(taken),
      .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
      .idex_bubble_o(idex_bubble), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
      .wb_rd_o(wb_rd), .wb_regwrite_o(wb_regwrite), .stall_cnt_o(stall_cnt)
   );

   // Narrow counter copy driven by the same stimulus, to reach saturation quickly.
   pipe_hazard_ctrl #(.RADDR_W(5), .CNT_W(4)) u_dut_sat (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .id_valid_i(id_valid),
      .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
      .id_rd_i(rd), .id_regwrite_i(regwrite), .id_memread_i(memread), .ex_taken_i(taken),
      .pc_write_o(unused_sat_pc), .ifid_write_o(unused_sat_ifw), .ifid_flush_o(unused_sat_fl),
      .idex_bubble_o(unused_sat_bb), .fwd_a_o(unused_sat_fa), .fwd_b_o(unused_sat_fb),
      .wb_rd_o(unused_sat_rd), .wb_regwrite_o(unused_sat_wr), .stall_cnt_o(sat_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] a, input logic ua,
                         input logic [4:0] b, input logic ub,
                         input logic [4:0] d, input logic rw, input logic mr);
      id_valid = v; rs1 = a; use1 = ua; rs2 = b; use2 = ub;
      rd = d; regwrite = rw; memread = mr;
   endtask

   task automatic nop();
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear();
      nop();
      repeat (3) tick();
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b1; taken = 1'b0;
      nop();
      @(negedge clk);
      #1;
      check("rst_cnt",    32'(stall_cnt), 32'd0);
      check("rst_fwd_a",  32'(fwd_a), 32'd0);
      check("rst_fwd_b",  32'(fwd_b), 32'd0);
      check("rst_wb_we",  32'(wb_regwrite), 32'd0);
      check("rst_pc_wr",  32'(pc_write), 32'd1);
      check("rst_bubble", 32'(idex_bubble), 32'd0);
      check("rst_flush",  32'(ifid_flush), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      clear();

`ifdef PIPE_FORWARD_EN
      // add x5 ; sub x6,x5,x1 -> forward from EX/MEM
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0); tick();
      set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0); #1;
      check("alu_nostall_pc", 32'(pc_write), 32'd1);
      check("alu_nostall_bb", 32'(idex_bubble), 32'd0);
      tick(); nop(); #1;
      check("fwd_mem_a", 32'(fwd_a), 32'b10);
      check("fwd_mem_b", 32'(fwd_b), 32'b00);
      // add x5 ; nop ; sub x6,x5,x1 -> forward from MEM/WB
      clear();
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0); tick();
      nop(); tick();
      set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0); tick();
      nop(); #1;
      check("fwd_wb_a", 32'(fwd_a), 32'b01);
      check("fwd_wb_b", 32'(fwd_b), 32'b00);
      // two producers of x5 back to back -> younger (MEM) wins
      clear();
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0); tick();
      set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0); tick();
      set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0); tick();
      nop(); #1;
      check("fwd_prio_a", 32'(fwd_a), 32'b10);
      // lw x5 ; add x7,x5,x5 -> one stall then forward via MEM/WB
      clear();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1); tick();
      set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0); #1;
      check("lu_pc_wr",   32'(pc_write), 32'd0);
      check("lu_ifid_wr", 32'(ifid_write), 32'd0);
      check("lu_bubble",  32'(idex_bubble), 32'd1);
      tick(); exp_cnt++; #1;
      check("lu_resume_pc", 32'(pc_write), 32'd1);
      check("lu_cnt",       32'(stall_cnt), 32'(exp_cnt));
      tick(); nop(); #1;
      check("lu_fwd_a", 32'(fwd_a), 32'b01);
      check("lu_fwd_b", 32'(fwd_b), 32'b01);
`else
      // add x5 ; add x6,x5,x0 -> two stalls, with a start_i pause in between
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0); tick();
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0); #1;
      check("nf_stall1_pc", 32'(pc_write), 32'd0);
      check("nf_stall1_bb", 32'(idex_bubble), 32'd1);
      check("nf_fwd_a",     32'(fwd_a), 32'd0);
      start = 1'b0; #1;
      check("hold_ifid_wr", 32'(ifid_write), 32'd0);
      check("hold_bubble",  32'(idex_bubble), 32'd1);
      tick();
      check("hold_cnt", 32'(stall_cnt), 32'(exp_cnt));
      start = 1'b1; #1;
      check("hold_still_stall", 32'(pc_write), 32'd0);
      tick(); exp_cnt++; #1;
      check("nf_stall2_pc", 32'(pc_write), 32'd0);
      check("nf_cnt1",      32'(stall_cnt), 32'(exp_cnt));
      tick(); exp_cnt++; #1;
      check("nf_resume_pc", 32'(pc_write), 32'd1);
      check("nf_wb_rd",     32'(wb_rd), 32'd5);
      check("nf_wb_we",     32'(wb_regwrite), 32'd1);
      check("nf_cnt2",      32'(stall_cnt), 32'(exp_cnt));
      tick(); nop(); #1;
      check("nf_fwd_a_ex", 32'(fwd_a), 32'd0);
      check("nf_fwd_b_ex", 32'(fwd_b), 32'd0);
`endif

      // load-use coincident with a taken branch: flush wins, no count
      clear();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1); tick();
      set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
      taken = 1'b1; #1;
      check("br_flush",  32'(ifid_flush), 32'd1);
      check("br_bubble", 32'(idex_bubble), 32'd1);
      check("br_pc_wr",  32'(pc_write), 32'd1);
      tick(); taken = 1'b0; nop(); #1;
      check("br_cnt", 32'(stall_cnt), 32'(exp_cnt));

      // producer of x0 then consumer of x0: never a hazard
      clear();
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1); tick();
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0); #1;
      check("x0_pc_wr",  32'(pc_write), 32'd1);
      check("x0_bubble", 32'(idex_bubble), 32'd0);
      tick(); nop(); #1;
      check("x0_fwd_a", 32'(fwd_a), 32'd0);
      check("x0_fwd_b", 32'(fwd_b), 32'd0);

      // asynchronous reset in the middle of a stall
      clear();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1); tick();
      set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
`ifndef PIPE_FORWARD_EN
      tick(); exp_cnt++;
`endif
      #1;
      check("mid_stall_pc", 32'(pc_write), 32'd0);
      rst_n = 1'b0; #1;
      exp_cnt = 0;
      check("arst_pc_wr",  32'(pc_write), 32'd1);
      check("arst_bubble", 32'(idex_bubble), 32'd0);
      check("arst_cnt",    32'(stall_cnt), 32'(exp_cnt));
      check("arst_wb_we",  32'(wb_regwrite), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // self-dependent instruction held in ID for 60 edges
      clear();
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      repeat (60) tick();
`ifdef PIPE_FORWARD_EN
      exp_cnt += 30;
`else
      exp_cnt += 40;
`endif
      nop(); #1;
      check("sat_wide_cnt",   32'(stall_cnt), 32'(exp_cnt));
      check("sat_narrow_cnt", 32'(sat_cnt), 32'hF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard-detection, forwarding-select and stage-tracking controller for the 5-stage pipelined successor of the single-cycle RV32 core.
- Tracks destination/control metadata of instructions in the EX, MEM and WB stages.
- Compares it with the instruction in ID to produce stall, bubble, flush and operand-forwarding selects.
- Sits between the Control/Registers decode logic and the pipeline datapath registers; drives the register-file write port address.

## Interface
Parameters:
- RADDR_W, 5, register-address width (x0 hard-wired zero)
- CNT_W, 16, width of saturating stall counter

Ports (`rst_n_i` is **asynchronous, active-low**):
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  pipeline advance enable; low freezes all stage state
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i / id_rs2_i  in  RADDR_W  ID source addresses
- id_use_rs1_i / id_use_rs2_i  in  1  ID instruction reads that source
- id_rd_i  in  RADDR_W  ID destination
- id_regwrite_i / id_memread_i  in  1  ID control bits
- ex_taken_i  in  1  branch in EX resolved taken
- pc_write_o  out  1  PC may update
- ifid_write_o  out  1  IF/ID register may load
- ifid_flush_o  out  1  IF/ID loads a bubble
- idex_bubble_o  out  1  ID/EX loads a bubble (control zeroed)
- fwd_a_o / fwd_b_o  out  2  EX operand select: 00 ID/EX, 10 EX/MEM, 01 MEM/WB
- wb_rd_o  out  RADDR_W  register-file write address
- wb_regwrite_o  out  1  register-file write enable
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- Internal stage records EX/MEM/WB each hold: valid, rs1, rs2 (EX only), rd, regwrite, memread.
- On each advancing edge:
  - ID → EX, unless a bubble is inserted (EX.valid=0).
  - EX → MEM.
  - MEM → WB.
- A stage "writes r" iff valid & regwrite & rd==r & r!=0.
- Load-use hazard (`hz`): id_valid_i, EX.memread, and EX writes id_rs1_i (with id_use_rs1_i) or id_rs2_i (with id_use_rs2_i).
- Stall (`stall` = hz & ~ex_taken_i):
  - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
  - Otherwise pc_write_o = ifid_write_o = start_i.
- Flush (`ex_taken_i`=1): ifid_flush_o=1, idex_bubble_o=1, pc_write_o=start_i. Flush overrides stall.
- Forwarding for EX operand A (B identical using EX.rs2):
  - 10 if MEM writes EX.rs1 and MEM is not a load;
  - else 01 if WB writes EX.rs1;
  - else 00.
  - MEM has priority over WB (youngest value wins).
- wb_rd_o = WB.rd; wb_regwrite_o = WB.valid & WB.regwrite.
- The register file must write-then-read in the same cycle, so no WB→ID hazard exists.
- stall_cnt_o increments on each edge where stall & start_i, and saturates at all-ones.

## Timing
- All hazard, forward and enable outputs are combinational from the stage records and ID/branch inputs; same-cycle response.
- Stage records and counter update on clk_i rising edge only when start_i=1.
- start_i=0: all records and the counter hold. pc_write_o=0, ifid_write_o=0; flush and bubble outputs still reflect their conditions.
- Load-use costs exactly 1 stall cycle with forwarding; the load reaches MEM→WB and forwards via 01.
- Taken branch costs 2 bubbles (IF/ID flush plus ID/EX bubble).
- Reset (async assert, sync deassert at the top level):
  - All valid=0, all addresses 0, stall_cnt_o=0.
  - Hence fwd_*_o=00, wb_regwrite_o=0, idex_bubble_o=0, ifid_flush_o=0, pc_write_o=start_i.
- Reset mid-stall drops the stall immediately and discards in-flight records.

## Configuration
- `PIPE_FORWARD_EN` defined: forwarding as above; only load-use stalls.
- `PIPE_FORWARD_EN` undefined:
  - fwd_a_o and fwd_b_o are tied to 00.
  - hz is redefined as: ID uses a source that EX or MEM writes (any instruction type).
  - Each dependent instruction therefore stalls until its producer reaches WB.

## Test plan
- Reset with start_i=1 → stall_cnt_o=0, fwd=00, wb_regwrite_o=0, pc_write_o=1.
- `add x5,..` then `sub x6,x5,x1` (forwarding on) → in sub's EX cycle fwd_a_o=10, no stall. With one instruction between them → fwd_a_o=01.
- `lw x5` then `add x7,x5,x5` → exactly 1 cycle with pc_write_o=0 and idex_bubble_o=1, then fwd_a_o=fwd_b_o=01; stall_cnt_o=1.
- Load-use stall coincident with ex_taken_i=1 → ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1, stall_cnt_o unchanged.
- Producer writing x0 followed by a consumer of x0 → no stall, fwd=00. 65540 forced stalls with CNT_W=16 → stall_cnt_o=0xFFFF.
- Forwarding compiled out: `add x5` then `add x6,x5,x0` → 2 stall cycles, fwd always 00. Assert rst_n_i during the 2nd stall cycle → outputs return to reset values without waiting for a clock edge.
